// File: rtl/trigger_cfg_sequencer.sv
// AXI4-Lite master that writes a table of words to the trigger register block
// and optionally reads every word back to confirm it.
//
// state     | meaning
// S_IDLE    | waiting for start_i
// S_WR_REQ  | AW/W valid, each dropped after its own handshake
// S_WR_RESP | BREADY high, waiting for the write response
// S_RD_REQ  | ARVALID held until ARREADY
// S_RD_RESP | RREADY high, checking RRESP and readback data
// S_DONE    | sequence complete, done_o held
// S_ERR     | sequence aborted, error_o / err_code_o / err_idx_o held
module trigger_cfg_sequencer #(
  parameter int unsigned NUM_REGS       = 4,
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter int unsigned BASE_ADDR      = 0,
  parameter bit          VERIFY         = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic                    start_i,
  input  logic [NUM_REGS*32-1:0]  cfg_data_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    error_o,
  output logic [2:0]              err_code_o,
  output logic [3:0]              err_idx_o,
  output logic                    timeout_o,
  output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]              M_AXI_AWPROT,
  output logic                    M_AXI_AWVALID,
  input  logic                    M_AXI_AWREADY,
  output logic [31:0]             M_AXI_WDATA,
  output logic [3:0]              M_AXI_WSTRB,
  output logic                    M_AXI_WVALID,
  input  logic                    M_AXI_WREADY,
  input  logic [1:0]              M_AXI_BRESP,
  input  logic                    M_AXI_BVALID,
  output logic                    M_AXI_BREADY,
  output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]              M_AXI_ARPROT,
  output logic                    M_AXI_ARVALID,
  input  logic                    M_AXI_ARREADY,
  input  logic [31:0]             M_AXI_RDATA,
  input  logic [1:0]              M_AXI_RRESP,
  input  logic                    M_AXI_RVALID,
  output logic                    M_AXI_RREADY
);

  localparam int unsigned     CW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]   TMO_MAX  = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0]   TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]      LAST_IDX = 4'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_RESP, S_DONE, S_ERR
  } state_t;

  state_t                r_state;
  logic [3:0]            r_idx;
  logic [CW-1:0]         r_tmo_cnt;
  logic                  r_busy, r_done, r_error, r_timeout;
  logic [2:0]            r_err_code;
  logic [3:0]            r_err_idx;
  logic [ADDR_WIDTH-1:0] r_awaddr, r_araddr;
  logic [31:0]           r_wdata;
  logic                  r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;

  logic        w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs, w_any_hs, w_wait;
  logic [3:0]  w_idx_inc;
  logic [31:0] w_word_cur, w_word_inc;
  logic [2:0]  w_fail_code;

  function automatic logic [ADDR_WIDTH-1:0] f_addr(input logic [3:0] idx);
    logic [31:0] a;
    a = BASE_ADDR + {26'd0, idx, 2'b00};
    return a[ADDR_WIDTH-1:0];
  endfunction

  assign w_aw_hs    = r_awvalid & M_AXI_AWREADY;
  assign w_w_hs     = r_wvalid & M_AXI_WREADY;
  assign w_b_hs     = r_bready & M_AXI_BVALID;
  assign w_ar_hs    = r_arvalid & M_AXI_ARREADY;
  assign w_r_hs     = r_rready & M_AXI_RVALID;
  assign w_any_hs   = w_aw_hs | w_w_hs | w_b_hs | w_ar_hs | w_r_hs;
  assign w_wait     = (r_state == S_WR_REQ) || (r_state == S_WR_RESP) ||
                      (r_state == S_RD_REQ) || (r_state == S_RD_RESP);
  assign w_idx_inc  = r_idx + 4'd1;
  assign w_word_cur = 32'(cfg_data_i >> {r_idx, 5'b0});
  assign w_word_inc = 32'(cfg_data_i >> {w_idx_inc, 5'b0});

  // Response errors outrank a timeout; a timeout outranks a data mismatch.
  always_comb begin
    w_fail_code = 3'd0;
    if (r_state == S_WR_RESP) begin
      if (M_AXI_BRESP != 2'b00)  w_fail_code = 3'd1;
      else if (r_timeout)        w_fail_code = 3'd4;
    end else if (r_state == S_RD_RESP) begin
      if (M_AXI_RRESP != 2'b00)           w_fail_code = 3'd2;
      else if (r_timeout)                 w_fail_code = 3'd4;
      else if (M_AXI_RDATA != w_word_cur) w_fail_code = 3'd3;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_tmo_cnt  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_timeout  <= 1'b0;
      r_err_code <= '0;
      r_err_idx  <= '0;
      r_awaddr   <= '0;
      r_araddr   <= '0;
      r_wdata    <= '0;
      r_awvalid  <= 1'b0;
      r_wvalid   <= 1'b0;
      r_bready   <= 1'b0;
      r_arvalid  <= 1'b0;
      r_rready   <= 1'b0;
    end else begin
      if (w_any_hs) begin
        r_tmo_cnt <= '0;
      end else if (w_wait && (r_tmo_cnt != TMO_MAX)) begin
        r_tmo_cnt <= r_tmo_cnt + CW'(1);
        if (r_tmo_cnt == TMO_LAST) r_timeout <= 1'b1;
      end

      if ((w_b_hs || w_r_hs) && (w_fail_code != 3'd0)) begin
        r_state    <= S_ERR;
        r_busy     <= 1'b0;
        r_error    <= 1'b1;
        r_err_code <= w_fail_code;
        r_err_idx  <= r_idx;
        r_bready   <= 1'b0;
        r_rready   <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE, S_DONE, S_ERR: begin
            if (start_i) begin
              r_state    <= S_WR_REQ;
              r_busy     <= 1'b1;
              r_done     <= 1'b0;
              r_error    <= 1'b0;
              r_err_code <= '0;
              r_err_idx  <= '0;
              r_timeout  <= 1'b0;
              r_tmo_cnt  <= '0;
              r_idx      <= '0;
              r_awvalid  <= 1'b1;
              r_wvalid   <= 1'b1;
              r_awaddr   <= f_addr(4'd0);
              r_wdata    <= 32'(cfg_data_i);
            end
          end
          S_WR_REQ: begin
            if (w_aw_hs) r_awvalid <= 1'b0;
            if (w_w_hs)  r_wvalid  <= 1'b0;
            if ((!r_awvalid || M_AXI_AWREADY) && (!r_wvalid || M_AXI_WREADY)) begin
              r_state  <= S_WR_RESP;
              r_bready <= 1'b1;
            end
          end
          S_WR_RESP: begin
            if (w_b_hs) begin
              r_bready <= 1'b0;
              if (r_idx != LAST_IDX) begin
                r_state   <= S_WR_REQ;
                r_idx     <= w_idx_inc;
                r_awvalid <= 1'b1;
                r_wvalid  <= 1'b1;
                r_awaddr  <= f_addr(w_idx_inc);
                r_wdata   <= w_word_inc;
              end else if (VERIFY) begin
                r_state   <= S_RD_REQ;
                r_idx     <= '0;
                r_arvalid <= 1'b1;
                r_araddr  <= f_addr(4'd0);
              end else begin
                r_state <= S_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end
          end
          S_RD_REQ: begin
            if (w_ar_hs) begin
              r_arvalid <= 1'b0;
              r_rready  <= 1'b1;
              r_state   <= S_RD_RESP;
            end
          end
          S_RD_RESP: begin
            if (w_r_hs) begin
              r_rready <= 1'b0;
              if (r_idx != LAST_IDX) begin
                r_state   <= S_RD_REQ;
                r_idx     <= w_idx_inc;
                r_arvalid <= 1'b1;
                r_araddr  <= f_addr(w_idx_inc);
              end else begin
                r_state <= S_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign busy_o        = r_busy;
  assign done_o        = r_done;
  assign error_o       = r_error;
  assign err_code_o    = r_err_code;
  assign err_idx_o     = r_err_idx;
  assign timeout_o     = r_timeout;
  assign M_AXI_AWADDR  = r_awaddr;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = r_awvalid;
  assign M_AXI_WDATA   = r_wdata;
  assign M_AXI_WSTRB   = 4'hF;
  assign M_AXI_WVALID  = r_wvalid;
  assign M_AXI_BREADY  = r_bready;
  assign M_AXI_ARADDR  = r_araddr;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = r_arvalid;
  assign M_AXI_RREADY  = r_rready;

endmodule

// File: tb/tb_trigger_cfg_sequencer.sv
// Bench for trigger_cfg_sequencer: AXI4-Lite memory slave with ready delays and
// fault injection, compared against a per-register model of the expected run.
module tb_trigger_cfg_sequencer;
  localparam int N  = 4;
  localparam int AW = 4;

  logic ACLK = 1'b0;
  logic ARESETN = 1'b0;
  logic start_i = 1'b0;
  logic [N*32-1:0] cfg_data_i = '0;
  logic busy_o, done_o, error_o, timeout_o;
  logic [2:0] err_code_o;
  logic [3:0] err_idx_o;
  logic [AW-1:0] M_AXI_AWADDR, M_AXI_ARADDR;
  logic [2:0] M_AXI_AWPROT, M_AXI_ARPROT;
  logic M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic [31:0] M_AXI_WDATA, M_AXI_RDATA;
  logic [3:0] M_AXI_WSTRB;
  logic [1:0] M_AXI_BRESP, M_AXI_RRESP;
  logic M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic M_AXI_RVALID, M_AXI_RREADY;

  always #5 ACLK = ~ACLK;

  trigger_cfg_sequencer #(.NUM_REGS(N), .ADDR_WIDTH(AW), .BASE_ADDR(0),
                          .VERIFY(1'b1), .TIMEOUT_CYCLES(1024)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .start_i(start_i), .cfg_data_i(cfg_data_i),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .err_code_o(err_code_o),
    .err_idx_o(err_idx_o), .timeout_o(timeout_o),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  // Slave knobs: total cycles each VALID is held, and fault injection indices
  int aw_hold = 1, w_hold = 1, berr_idx = -1, rzero_idx = -1;
  int aw_wait, w_wait, ar_cnt, awv_cyc, wv_cyc;
  int wr_cnt [N];
  logic [31:0] mem [N];
  logic aw_got, w_got, a_ok, d_ok;
  logic [AW-1:0] aw_a, a_val;
  logic [31:0] w_d, d_val;

  int errors = 0;
  int checks = 0;

  assign M_AXI_AWREADY = M_AXI_AWVALID && (aw_wait >= aw_hold - 1);
  assign M_AXI_WREADY  = M_AXI_WVALID && (w_wait >= w_hold - 1);
  assign M_AXI_ARREADY = 1'b1;

  always @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_wait <= 0; w_wait <= 0; aw_got <= 1'b0; w_got <= 1'b0;
      aw_a <= '0; w_d <= '0; ar_cnt <= 0; awv_cyc <= 0; wv_cyc <= 0;
      M_AXI_BVALID <= 1'b0; M_AXI_BRESP <= 2'b00;
      M_AXI_RVALID <= 1'b0; M_AXI_RRESP <= 2'b00; M_AXI_RDATA <= '0;
      for (int k = 0; k < N; k++) begin mem[k] <= '0; wr_cnt[k] <= 0; end
    end else begin
      aw_wait <= (M_AXI_AWVALID && !M_AXI_AWREADY) ? aw_wait + 1 : 0;
      w_wait  <= (M_AXI_WVALID && !M_AXI_WREADY) ? w_wait + 1 : 0;
      awv_cyc <= awv_cyc + (M_AXI_AWVALID ? 1 : 0);
      wv_cyc  <= wv_cyc + (M_AXI_WVALID ? 1 : 0);
      a_ok  = aw_got || (M_AXI_AWVALID && M_AXI_AWREADY);
      d_ok  = w_got || (M_AXI_WVALID && M_AXI_WREADY);
      a_val = aw_got ? aw_a : M_AXI_AWADDR;
      d_val = w_got ? w_d : M_AXI_WDATA;
      if (M_AXI_BVALID && M_AXI_BREADY) M_AXI_BVALID <= 1'b0;
      if (a_ok && d_ok) begin
        mem[a_val[3:2]]    <= d_val;
        wr_cnt[a_val[3:2]] <= wr_cnt[a_val[3:2]] + 1;
        M_AXI_BVALID <= 1'b1;
        M_AXI_BRESP  <= (int'(a_val[3:2]) == berr_idx) ? 2'b10 : 2'b00;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end else begin
        aw_got <= a_ok;
        w_got  <= d_ok;
        if (M_AXI_AWVALID && M_AXI_AWREADY) aw_a <= M_AXI_AWADDR;
        if (M_AXI_WVALID && M_AXI_WREADY)   w_d  <= M_AXI_WDATA;
      end
      if (M_AXI_RVALID && M_AXI_RREADY) M_AXI_RVALID <= 1'b0;
      if (M_AXI_ARVALID && M_AXI_ARREADY) begin
        ar_cnt       <= ar_cnt + 1;
        M_AXI_RVALID <= 1'b1;
        M_AXI_RDATA  <= (int'(M_AXI_ARADDR[3:2]) == rzero_idx) ? 32'h0 : mem[M_AXI_ARADDR[3:2]];
      end
    end
  end

  // Expected outcome of one run: writes go in order until a bad BRESP, then
  // reads go in order until a zeroed readback differs from the table word.
  task automatic model(input logic [N*32-1:0] tbl, input int berr, input int rzero,
                       output int code, output int idx, output int nwr, output int nar);
    logic [N*32-1:0] t;
    code = 0; idx = 0; nwr = N; nar = N; t = tbl;
    for (int i = 0; i < N; i++)
      if (i == berr) begin code = 1; idx = i; nwr = i + 1; nar = 0; return; end
    for (int i = 0; i < N; i++)
      if (i == rzero && t[32*i +: 32] != 32'h0) begin code = 3; idx = i; nar = i + 1; return; end
  endtask

  task automatic apply_reset();
    aw_hold = 1; w_hold = 1; berr_idx = -1; rzero_idx = -1; start_i = 1'b0;
    ARESETN = 1'b0;
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);
  endtask

  task automatic pulse_start();
    @(negedge ACLK); start_i = 1'b1;
    @(negedge ACLK); start_i = 1'b0;
  endtask

  task automatic wait_end(input int c0, output int c);
    c = c0;
    while (!(done_o || error_o) && c < 3000) begin @(negedge ACLK); c++; end
    checks++;
    if (!(done_o || error_o)) begin
      errors++;
      $display("FAIL wait_end: no done/error after %0d cycles (required done_o or error_o = 1)", c);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({busy_o, done_o, error_o, timeout_o, err_code_o, err_idx_o, M_AXI_AWVALID,
         M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b err=%b tmo=%b code=%0d idx=%0d awv=%b wv=%b br=%b arv=%b rr=%b, required all 0",
               busy_o, done_o, error_o, timeout_o, err_code_o, err_idx_o, M_AXI_AWVALID,
               M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY);
    end
  endtask

  task automatic test_basic();
    int lat;
    apply_reset();
    cfg_data_i = {32'h4, 32'h3, 32'h2, 32'h1};
    pulse_start();
    checks++;
    if ({busy_o, M_AXI_AWVALID, M_AXI_WVALID} !== 3'b111 || M_AXI_AWADDR !== 4'h0 ||
        M_AXI_WDATA !== 32'h1) begin
      errors++;
      $display("FAIL basic_first_write: busy/awv/wv=%b addr=%h data=%h, required 111 0 00000001",
               {busy_o, M_AXI_AWVALID, M_AXI_WVALID}, M_AXI_AWADDR, M_AXI_WDATA);
    end
    checks++;
    if (M_AXI_WSTRB !== 4'hF || M_AXI_AWPROT !== 3'b0 || M_AXI_ARPROT !== 3'b0) begin
      errors++;
      $display("FAIL basic_fixed: wstrb=%h awprot=%0d arprot=%0d, required F 0 0",
               M_AXI_WSTRB, M_AXI_AWPROT, M_AXI_ARPROT);
    end
    wait_end(1, lat);
    checks++;
    if (lat != 17) begin
      errors++; $display("FAIL basic_latency: %0d cycles, required 17", lat);
    end
    checks++;
    if ({done_o, error_o, busy_o} !== 3'b100 || err_code_o !== 3'd0 || ar_cnt != 4) begin
      errors++;
      $display("FAIL basic_status: done/err/busy=%b code=%0d reads=%0d, required 100 0 4",
               {done_o, error_o, busy_o}, err_code_o, ar_cnt);
    end
    for (int j = 0; j < N; j++) begin
      checks++;
      if (mem[j] !== 32'(j + 1) || wr_cnt[j] != 1) begin
        errors++;
        $display("FAIL basic_mem[%0d]: data=%h writes=%0d, required %h 1", j, mem[j], wr_cnt[j], j + 1);
      end
    end
  endtask

  task automatic test_aw_delay();
    int lat;
    apply_reset();
    aw_hold = 3;
    cfg_data_i = {32'h4, 32'h3, 32'h2, 32'h1};
    pulse_start();
    wait_end(1, lat);
    checks++;
    if (awv_cyc != 12 || wv_cyc != 4) begin
      errors++;
      $display("FAIL aw_delay_valid: awvalid cycles=%0d wvalid cycles=%0d, required 12 4", awv_cyc, wv_cyc);
    end
    checks++;
    if (done_o !== 1'b1 || error_o !== 1'b0) begin
      errors++; $display("FAIL aw_delay_status: done=%b err=%b, required 1 0", done_o, error_o);
    end
    for (int j = 0; j < N; j++) begin
      checks++;
      if (mem[j] !== 32'(j + 1) || wr_cnt[j] != 1) begin
        errors++;
        $display("FAIL aw_delay_mem[%0d]: data=%h writes=%0d, required %h 1", j, mem[j], wr_cnt[j], j + 1);
      end
    end
  endtask

  task automatic test_bresp_err();
    int lat;
    apply_reset();
    berr_idx = 2;
    cfg_data_i = {32'h4, 32'h3, 32'h2, 32'h1};
    pulse_start();
    wait_end(1, lat);
    checks++;
    if ({done_o, error_o} !== 2'b01 || err_code_o !== 3'd1 || err_idx_o !== 4'd2) begin
      errors++;
      $display("FAIL bresp_status: done/err=%b code=%0d idx=%0d, required 01 1 2",
               {done_o, error_o}, err_code_o, err_idx_o);
    end
    checks++;
    if (ar_cnt != 0 || wr_cnt[3] != 0) begin
      errors++;
      $display("FAIL bresp_traffic: reads=%0d writes[3]=%0d, required 0 0", ar_cnt, wr_cnt[3]);
    end
  endtask

  task automatic test_rdata_mismatch();
    int lat;
    apply_reset();
    rzero_idx = 1;
    cfg_data_i = {32'h4, 32'h3, 32'h2, 32'h1};
    pulse_start();
    wait_end(1, lat);
    checks++;
    if ({done_o, error_o} !== 2'b01 || err_code_o !== 3'd3 || err_idx_o !== 4'd1 || ar_cnt != 2) begin
      errors++;
      $display("FAIL mismatch_status: done/err=%b code=%0d idx=%0d reads=%0d, required 01 3 1 2",
               {done_o, error_o}, err_code_o, err_idx_o, ar_cnt);
    end
  endtask

  task automatic test_timeout();
    int lat, stalls;
    apply_reset();
    aw_hold = 1101;
    cfg_data_i = {32'h4, 32'h3, 32'h2, 32'h1};
    pulse_start();
    stalls = 0;
    for (int c = 0; c < 1200 && M_AXI_AWVALID; c++) begin
      if (!M_AXI_AWREADY) stalls++;
      if (stalls == 1000) begin
        checks++;
        if (timeout_o !== 1'b0) begin
          errors++; $display("FAIL timeout_early: timeout_o=%b after 1000 stalls, required 0", timeout_o);
        end
      end
      @(negedge ACLK);
    end
    checks++;
    if (stalls != 1100 || timeout_o !== 1'b1) begin
      errors++;
      $display("FAIL timeout_flag: awvalid stalls=%0d timeout_o=%b, required 1100 1", stalls, timeout_o);
    end
    wait_end(1, lat);
    checks++;
    if ({error_o, timeout_o} !== 2'b11 || err_code_o !== 3'd4 || err_idx_o !== 4'd0 ||
        wr_cnt[0] != 1 || ar_cnt != 0) begin
      errors++;
      $display("FAIL timeout_status: err/tmo=%b code=%0d idx=%0d writes[0]=%0d reads=%0d, required 11 4 0 1 0",
               {error_o, timeout_o}, err_code_o, err_idx_o, wr_cnt[0], ar_cnt);
    end
  endtask

  task automatic test_reset_midrun();
    int lat, c;
    apply_reset();
    cfg_data_i = {32'h44, 32'h33, 32'h22, 32'h11};
    pulse_start();
    c = 0;
    while (!(M_AXI_WVALID && M_AXI_AWADDR == 4'h8) && c < 40) begin @(negedge ACLK); c++; end
    #2 ARESETN = 1'b0;
    #1;
    checks++;
    if ({busy_o, done_o, error_o, timeout_o, err_code_o, err_idx_o, M_AXI_AWVALID,
         M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY} !== '0 || c >= 40) begin
      errors++;
      $display("FAIL midrun_reset: busy=%b awv=%b wv=%b code=%0d wait=%0d, required all outputs 0 at idx 2",
               busy_o, M_AXI_AWVALID, M_AXI_WVALID, err_code_o, c);
    end
    @(negedge ACLK); ARESETN = 1'b1;
    @(negedge ACLK);
    pulse_start();
    repeat (4) @(negedge ACLK);
    start_i = 1'b1;
    @(negedge ACLK); start_i = 1'b0;
    wait_end(6, lat);
    checks++;
    if (lat != 17 || done_o !== 1'b1 || error_o !== 1'b0) begin
      errors++;
      $display("FAIL midrun_restart: latency=%0d done=%b err=%b, required 17 1 0", lat, done_o, error_o);
    end
    for (int j = 0; j < N; j++) begin
      checks++;
      if (wr_cnt[j] != 1 || mem[j] !== 32'((j + 1) * 32'h11)) begin
        errors++;
        $display("FAIL midrun_mem[%0d]: data=%h writes=%0d, required %h 1", j, mem[j], wr_cnt[j], (j + 1) * 32'h11);
      end
    end
  endtask

  task automatic test_random();
    int lat, code, idx, nwr, nar, mode;
    logic [N*32-1:0] tbl;
    for (int it = 0; it < 8; it++) begin
      apply_reset();
      for (int j = 0; j < N; j++) tbl[32*j +: 32] = $urandom;
      cfg_data_i = tbl;
      aw_hold = $urandom_range(1, 3);
      w_hold  = $urandom_range(1, 3);
      mode = $urandom_range(0, 2);
      if (mode == 1) berr_idx  = $urandom_range(0, N - 1);
      if (mode == 2) rzero_idx = $urandom_range(0, N - 1);
      model(tbl, berr_idx, rzero_idx, code, idx, nwr, nar);
      pulse_start();
      wait_end(1, lat);
      checks++;
      if (err_code_o !== 3'(code) || error_o !== (code != 0) || done_o !== (code == 0) ||
          (code != 0 && err_idx_o !== 4'(idx)) || ar_cnt != nar) begin
        errors++;
        $display("FAIL random[%0d]_status: code=%0d idx=%0d err=%b done=%b reads=%0d, required %0d %0d %b %b %0d",
                 it, err_code_o, err_idx_o, error_o, done_o, ar_cnt, code, idx, code != 0, code == 0, nar);
      end
      for (int j = 0; j < N; j++) begin
        checks++;
        if (wr_cnt[j] != (j < nwr ? 1 : 0) || mem[j] !== (j < nwr ? tbl[32*j +: 32] : 32'h0)) begin
          errors++;
          $display("FAIL random[%0d]_mem[%0d]: data=%h writes=%0d, required %h %0d", it, j, mem[j],
                   wr_cnt[j], (j < nwr ? tbl[32*j +: 32] : 32'h0), (j < nwr ? 1 : 0));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_aw_delay();
    test_bresp_err();
    test_rdata_mismatch();
    test_timeout();
    test_reset_midrun();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
